// File: rtl/fwd_km_seq_if.sv
// Command, cosine-unit and pose signal bundle for fwd_km_seq.
// The slave modport is the kinematics core. The master modport is the side that issues commands and hosts the cosine unit.
interface fwd_km_seq_if #(
  parameter int ANG_W = 32,
  parameter int COS_W = 32,
  parameter int OUT_W = 64
);
  logic                    home;
  logic                    in_valid;
  logic                    in_ready;
  logic [ANG_W-1:0]        jnt_0;
  logic [ANG_W-1:0]        jnt_1;
  logic [ANG_W-1:0]        jnt_2;
  logic                    cos_req;
  logic [ANG_W-1:0]        cos_ang;
  logic                    cos_rsp_valid;
  logic signed [COS_W-1:0] cos_rsp;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] ee_x;
  logic signed [OUT_W-1:0] ee_y;
  logic signed [OUT_W-1:0] ee_z;
  logic                    ovf;

  modport master (
    output home, in_valid, jnt_0, jnt_1, jnt_2, cos_rsp_valid, cos_rsp, out_ready,
    input  in_ready, cos_req, cos_ang, out_valid, ee_x, ee_y, ee_z, ovf
  );

  modport slave (
    input  home, in_valid, jnt_0, jnt_1, jnt_2, cos_rsp_valid, cos_rsp, out_ready,
    output in_ready, cos_req, cos_ang, out_valid, ee_x, ee_y, ee_z, ovf
  );
endinterface

// File: rtl/fwd_km_seq.sv
// Sequential arm forward kinematics. It keeps an angle cache, uses one shared multiplier and calls an external cosine unit.
// Define FWDKM_SAT_EN to clamp each pose output to OUT_W and to latch any clamp on ovf.
module fwd_km_seq #(
  parameter int ANG_W = 32,
  parameter int COS_W = 32,
  parameter int OUT_W = 64,
  parameter int H  = 290,
  parameter int L1 = 524,
  parameter int L2 = 1064,
  parameter int L3 = 1687,
  parameter logic signed [COS_W-1:0] C2 = {2'b01, {(COS_W-2){1'b0}}},
  parameter logic signed [COS_W-1:0] S2 = '0,
  parameter logic [ANG_W-1:0] INIT0 = '0,
  parameter logic [ANG_W-1:0] INIT1 = '0,
  parameter logic [ANG_W-1:0] INIT2 = '0
) (
  input logic         clock,
  input logic         resetn,
  fwd_km_seq_if.slave bus
);

  localparam int F  = COS_W - 2;
  localparam int AW = OUT_W + COS_W + 4;
  localparam int PW = AW + COS_W;

  localparam logic [ANG_W-1:0]     Q_ANG  = {2'b01, {(ANG_W-2){1'b0}}};
  localparam logic signed [AW-1:0] H_A    = AW'(H);
  localparam logic signed [AW-1:0] L1_A   = AW'(L1);
  localparam logic signed [AW-1:0] L2_A   = AW'(L2);
  localparam logic signed [AW-1:0] L3_A   = AW'(L3);
  localparam logic signed [AW-1:0] C2_A   = AW'(C2);
  localparam logic signed [AW-1:0] S2_A   = AW'(S2);
  localparam logic signed [AW-1:0] Y_INIT = (H_A <<< F) + L1_A * S2_A;
  localparam logic signed [AW-1:0] R_INIT = L1_A * C2_A;

  typedef enum logic [2:0] {IDLE, UPD, REQ, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              k_q, k_d;
  logic [ANG_W-1:0]        th0_q, th0_d, th1_q, th1_d, th2_q, th2_d;
  logic [ANG_W-1:0]        dlt0_q, dlt0_d, dlt1_q, dlt1_d, dlt2_q, dlt2_d;
  logic signed [AW-1:0]    acc_y_q, acc_y_d, acc_r_q, acc_r_d;
  logic signed [AW-1:0]    x_q, x_d, z_q, z_d;
  logic signed [OUT_W-1:0] ee_x_q, ee_x_d, ee_y_q, ee_y_d, ee_z_q, ee_z_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_c;
  logic                    cos_req_c;
  logic [ANG_W-1:0]        cos_ang_c;
  logic signed [AW-1:0]    mul_a;
  logic signed [PW-1:0]    mul_a_ext, mul_b_ext, prod;
  logic signed [AW-1:0]    prod_lo, prod_fx;

`ifdef FWDKM_SAT_EN
  logic ovf_q, ovf_d;

  function automatic logic fits(input logic signed [AW-1:0] v);
    return (&v[AW-1:OUT_W-1]) | ~(|v[AW-1:OUT_W-1]);
  endfunction

  function automatic logic signed [OUT_W-1:0] clamp(input logic signed [AW-1:0] v);
    if (fits(v))
      return v[OUT_W-1:0];
    else if (v[AW-1])
      return {1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction
`endif

  // The single multiplier is shared by all six steps, and step k selects the left operand.
  always_comb begin
    mul_a     = acc_r_q;
    cos_ang_c = th0_q;
    case (k_q)
      3'd0: begin
        mul_a     = L2_A;
        cos_ang_c = th1_q - Q_ANG;
      end
      3'd1: begin
        mul_a     = L3_A;
        cos_ang_c = th2_q - Q_ANG;
      end
      3'd2: begin
        mul_a     = L3_A;
        cos_ang_c = th2_q;
      end
      3'd3: begin
        mul_a     = L2_A;
        cos_ang_c = th1_q;
      end
      3'd4: begin
        mul_a     = acc_r_q;
        cos_ang_c = th0_q;
      end
      default: begin
        mul_a     = acc_r_q;
        cos_ang_c = th0_q - Q_ANG;
      end
    endcase
    mul_a_ext = {{COS_W{mul_a[AW-1]}}, mul_a};
    mul_b_ext = {{AW{bus.cos_rsp[COS_W-1]}}, bus.cos_rsp};
    prod      = mul_a_ext * mul_b_ext;
    prod_lo   = AW'(prod);
    prod_fx   = AW'(prod >>> F);
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    th0_d       = th0_q;
    th1_d       = th1_q;
    th2_d       = th2_q;
    dlt0_d      = dlt0_q;
    dlt1_d      = dlt1_q;
    dlt2_d      = dlt2_q;
    acc_y_d     = acc_y_q;
    acc_r_d     = acc_r_q;
    x_d         = x_q;
    z_d         = z_q;
    ee_x_d      = ee_x_q;
    ee_y_d      = ee_y_q;
    ee_z_d      = ee_z_q;
    out_valid_d = out_valid_q;
    in_ready_c  = 1'b0;
    cos_req_c   = 1'b0;
`ifdef FWDKM_SAT_EN
    ovf_d       = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        in_ready_c = ~bus.home;
        if (bus.home) begin
          th0_d = INIT0;
          th1_d = INIT1;
          th2_d = INIT2;
        end else if (bus.in_valid) begin
          dlt0_d  = bus.jnt_0;
          dlt1_d  = bus.jnt_1;
          dlt2_d  = bus.jnt_2;
          state_d = UPD;
        end
      end

      // th2 absorbs the elbow delta so the wrist keeps its pitch relative to the base.
      UPD: begin
        th0_d   = th0_q + dlt0_q;
        th1_d   = th1_q + dlt1_q;
        th2_d   = th2_q - (dlt1_q + dlt2_q);
        acc_y_d = Y_INIT;
        acc_r_d = R_INIT;
        k_d     = 3'd0;
        state_d = REQ;
      end

      REQ: begin
        cos_req_c = 1'b1;
        state_d   = WAIT;
      end

      WAIT: begin
        if (bus.cos_rsp_valid) begin
          case (k_q)
            3'd0, 3'd1: acc_y_d = acc_y_q + prod_lo;
            3'd2:       acc_r_d = acc_r_q + prod_lo;
            3'd3:       acc_r_d = acc_r_q - prod_lo;
            3'd4:       z_d     = prod_fx;
            default:    x_d     = prod_fx;
          endcase
          if (k_q == 3'd5) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = REQ;
          end
        end
      end

      // The first DONE cycle loads the pose registers. After that, state waits for the consumer.
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
`ifdef FWDKM_SAT_EN
          ee_x_d = clamp(x_q);
          ee_y_d = clamp(acc_y_q);
          ee_z_d = clamp(z_q);
          ovf_d  = ovf_q | ~fits(x_q) | ~fits(acc_y_q) | ~fits(z_q);
`else
          ee_x_d = OUT_W'(x_q);
          ee_y_d = OUT_W'(acc_y_q);
          ee_z_d = OUT_W'(z_q);
`endif
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      th0_q       <= INIT0;
      th1_q       <= INIT1;
      th2_q       <= INIT2;
      dlt0_q      <= '0;
      dlt1_q      <= '0;
      dlt2_q      <= '0;
      acc_y_q     <= '0;
      acc_r_q     <= '0;
      x_q         <= '0;
      z_q         <= '0;
      ee_x_q      <= '0;
      ee_y_q      <= '0;
      ee_z_q      <= '0;
      out_valid_q <= 1'b0;
`ifdef FWDKM_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      th0_q       <= th0_d;
      th1_q       <= th1_d;
      th2_q       <= th2_d;
      dlt0_q      <= dlt0_d;
      dlt1_q      <= dlt1_d;
      dlt2_q      <= dlt2_d;
      acc_y_q     <= acc_y_d;
      acc_r_q     <= acc_r_d;
      x_q         <= x_d;
      z_q         <= z_d;
      ee_x_q      <= ee_x_d;
      ee_y_q      <= ee_y_d;
      ee_z_q      <= ee_z_d;
      out_valid_q <= out_valid_d;
`ifdef FWDKM_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.cos_req   = cos_req_c;
  assign bus.cos_ang   = cos_ang_c;
  assign bus.out_valid = out_valid_q;
  assign bus.ee_x      = ee_x_q;
  assign bus.ee_y      = ee_y_q;
  assign bus.ee_z      = ee_z_q;
`ifdef FWDKM_SAT_EN
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_km_seq.sv
// Directed bench for fwd_km_seq. A quarter-turn cosine model answers the external cosine requests.
// A second instance with OUT_W=16 and L3=2^14 exercises saturation or wrap, depending on FWDKM_SAT_EN.
module tb_fwd_km_seq;
  localparam logic [31:0] QT = 32'h4000_0000;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   vectors   = 0;
  int   errors    = 0;
  int   lc        = 1;
  int   req_count = 0;
  int   b2b_count = 0;
  logic prev_req  = 1'b0;

  always #5 clock = ~clock;

  fwd_km_seq_if #(.ANG_W(32), .COS_W(32), .OUT_W(64)) bus ();
  fwd_km_seq_if #(.ANG_W(32), .COS_W(32), .OUT_W(16)) sbus ();

  fwd_km_seq dut (.clock(clock), .resetn(resetn), .bus(bus));
  fwd_km_seq #(.OUT_W(16), .L3(16384)) sdut (.clock(clock), .resetn(resetn), .bus(sbus));

  function automatic logic [63:0] fx(input int v);
    return 64'(longint'(v) * 64'sd1073741824);
  endfunction

  function automatic logic signed [31:0] cos_model(input logic [31:0] a);
    case (a[31:30])
      2'd0:    return 32'sh4000_0000;
      2'd2:    return -32'sh4000_0000;
      default: return 32'sd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] j0, input logic [31:0] j1, input logic [31:0] j2);
    int waited = 0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.jnt_0 = j0;
    bus.jnt_1 = j1;
    bus.jnt_2 = j2;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("in_ready_at_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    do begin
      @(posedge clock);
      cycles++;
      #1;
    end while (!bus.out_valid && cycles < 200);
    checkOutput("out_valid_seen", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic releaseOutput();
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic runPose(input string tag, input logic [31:0] j0, input logic [31:0] j1,
                         input logic [31:0] j2, input int ex, input int ey, input int ez);
    int cyc;
    applyStimulus(j0, j1, j2);
    waitResult(cyc);
    checkOutput({tag, "_x"}, bus.ee_x, fx(ex));
    checkOutput({tag, "_y"}, bus.ee_y, fx(ey));
    checkOutput({tag, "_z"}, bus.ee_z, fx(ez));
    releaseOutput();
  endtask

  task automatic pulseHome();
    @(negedge clock);
    bus.home = 1'b1;
    #1;
    checkOutput("in_ready_during_home", 64'(bus.in_ready), 64'd0);
    @(posedge clock);
    #1;
    bus.home = 1'b0;
  endtask

  // Observes every cos_req pulse and flags back-to-back requests.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.cos_req === 1'b1) begin
        req_count++;
        if (prev_req) b2b_count++;
      end
      prev_req = bus.cos_req;
    end
  end

  // Cosine unit for the main instance. It answers lc cycles after each request.
  initial begin
    logic [31:0] ang;
    bus.cos_rsp_valid = 1'b0;
    bus.cos_rsp = '0;
    forever begin
      @(negedge clock);
      if (bus.cos_req === 1'b1) begin
        ang = bus.cos_ang;
        repeat (lc) @(posedge clock);
        #1;
        bus.cos_rsp_valid = 1'b1;
        bus.cos_rsp = cos_model(ang);
        @(posedge clock);
        #1;
        bus.cos_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] ang;
    sbus.cos_rsp_valid = 1'b0;
    sbus.cos_rsp = '0;
    forever begin
      @(negedge clock);
      if (sbus.cos_req === 1'b1) begin
        ang = sbus.cos_ang;
        @(posedge clock);
        #1;
        sbus.cos_rsp_valid = 1'b1;
        sbus.cos_rsp = cos_model(ang);
        @(posedge clock);
        #1;
        sbus.cos_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    int cyc;
    int base;
    int waited;
    bus.home = 1'b0;
    bus.in_valid = 1'b0;
    bus.jnt_0 = '0;
    bus.jnt_1 = '0;
    bus.jnt_2 = '0;
    bus.out_ready = 1'b0;
    sbus.home = 1'b0;
    sbus.in_valid = 1'b0;
    sbus.jnt_0 = '0;
    sbus.jnt_1 = '0;
    sbus.jnt_2 = '0;
    sbus.out_ready = 1'b0;

    repeat (3) @(negedge clock);
    resetn = 1'b1;
    #1;
    checkOutput("reset_ee_x", bus.ee_x, 64'd0);
    checkOutput("reset_ee_y", bus.ee_y, 64'd0);
    checkOutput("reset_ee_z", bus.ee_z, 64'd0);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_cos_req", 64'(bus.cos_req), 64'd0);
    checkOutput("reset_ovf", 64'(bus.ovf), 64'd0);
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);

    $display("[TB] home pose, Lc=1");
    base = req_count;
    applyStimulus('0, '0, '0);
    waitResult(cyc);
    checkOutput("home_latency", 64'(cyc), 64'd14);
    checkOutput("home_x", bus.ee_x, fx(0));
    checkOutput("home_y", bus.ee_y, fx(290));
    checkOutput("home_z", bus.ee_z, fx(1147));
    checkOutput("home_cos_pulses", 64'(req_count - base), 64'd6);
    releaseOutput();

    $display("[TB] base quarter turn");
    runPose("base_q", QT, '0, '0, 1147, 290, 0);

    $display("[TB] Lc=5 with a stalled consumer");
    lc = 5;
    base = req_count;
    applyStimulus('0, '0, '0);
    waitResult(cyc);
    checkOutput("lc5_latency", 64'(cyc), 64'd38);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      checkOutput("stall_out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall_x", bus.ee_x, fx(1147));
      checkOutput("stall_z", bus.ee_z, fx(0));
      checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    checkOutput("lc5_cos_pulses", 64'(req_count - base), 64'd6);
    releaseOutput();
    checkOutput("in_ready_after_release", 64'(bus.in_ready), 64'd1);
    checkOutput("out_valid_after_release", 64'(bus.out_valid), 64'd0);
    lc = 1;

    $display("[TB] home, then four elbow quarter turns");
    pulseHome();
    runPose("elbow1", '0, QT, '0, 0, -333, 524);
    runPose("elbow2", '0, QT, '0, 0, 290, -99);
    runPose("elbow3", '0, QT, '0, 0, 913, 524);
    runPose("elbow4", '0, QT, '0, 0, 290, 1147);

    $display("[TB] home restores the angle cache");
    runPose("pre_home", QT, '0, '0, 1147, 290, 0);
    pulseHome();
    runPose("post_home", '0, '0, '0, 0, 290, 1147);

    $display("[TB] reset during WAIT at k=3");
    lc = 5;
    base = req_count;
    applyStimulus(QT, '0, '0);
    waited = 0;
    while ((req_count - base) < 4 && waited < 200) begin
      @(posedge clock);
      #2;
      waited++;
    end
    checkOutput("reached_k3", 64'(req_count - base), 64'd4);
    resetn = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midrst_cos_req", 64'(bus.cos_req), 64'd0);
    checkOutput("midrst_ee_x", bus.ee_x, 64'd0);
    checkOutput("midrst_ee_y", bus.ee_y, 64'd0);
    checkOutput("midrst_ee_z", bus.ee_z, 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    checkOutput("postrst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      checkOutput("late_rsp_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("late_rsp_in_ready", 64'(bus.in_ready), 64'd1);
    end
    lc = 1;
    runPose("after_reset", '0, '0, '0, 0, 290, 1147);
    checkOutput("no_back_to_back", 64'(b2b_count), 64'd0);
    checkOutput("main_ovf", 64'(bus.ovf), 64'd0);

    $display("[TB] narrow instance, OUT_W=16, L3=2^14");
    @(negedge clock);
    sbus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    sbus.in_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge clock);
      cyc++;
      #1;
    end while (!sbus.out_valid && cyc < 200);
    checkOutput("narrow_out_valid", 64'(sbus.out_valid), 64'd1);
    checkOutput("narrow_x", 64'(sbus.ee_x), 64'd0);
`ifdef FWDKM_SAT_EN
    checkOutput("narrow_z_sat", 64'(sbus.ee_z), 64'd32767);
    checkOutput("narrow_y_sat", 64'(sbus.ee_y), 64'd32767);
    checkOutput("narrow_ovf", 64'(sbus.ovf), 64'd1);
`else
    checkOutput("narrow_z_wrap", 64'(sbus.ee_z), 64'd0);
    checkOutput("narrow_y_wrap", 64'(sbus.ee_y), 64'd0);
    checkOutput("narrow_ovf", 64'(sbus.ovf), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
